adc_sample_ctl: RTL and testbench
=================================

ADC_SAMPLE_CTL -- requirements
Module: adc_sample_ctl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter CLK_DIV, default 50, SHALL set the number of SYSCLK cycles per ADC_CLK period; it is even and at least 4.
REQ-003 Parameter CS_WAKE, default 8, SHALL set the number of ADC_CLK rising edges after ADC_CS assertion before any capture.
REQ-004 Parameter PIPE_LAT, default 3, SHALL set the number of captures discarded for ADC pipeline flush.
REQ-005 Port SYSCLK, input, 1 bit: system clock, 50 MHz.
REQ-006 Port RST_B, input, 1 bit: asynchronous active-high reset; the name is kept for the codebase, but the polarity is high.
REQ-007 Port ADC_DAT, input, 8 bits: parallel ADC output bus.
REQ-008 Port ADC_CS, output, 1 bit: ADC chip select, active low.
REQ-009 Port ADC_CLK, output, 1 bit: ADC conversion clock.
REQ-010 Port ADC_DATA_REC, output, 8 bits: latest accepted sample.

Function
REQ-011 Divider counter SHALL cycle 0..CLK_DIV-1 and free-run from reset release.
- ADC_CLK SHALL be registered: 0 while the counter is below CLK_DIV/2, 1 otherwise.
REQ-012 The state machine SHALL have three states:
- IDLE: ADC_CS=1, lasts one SYSCLK cycle, then goes to WAKE.
- WAKE: ADC_CS=0; goes to RUN after CS_WAKE ADC_CLK rising edges.
- RUN: ADC_CS=0; stays in RUN until reset.
REQ-013 Capture event SHALL be the SYSCLK edge that drives ADC_CLK 0->1; ADC_DAT is sampled directly, with no synchronizer.
REQ-014 The first PIPE_LAT capture events in RUN SHALL be discarded; every later capture is accepted.
REQ-015 ADC_DATA_REC SHALL update exactly one SYSCLK cycle after an accepted capture and hold its value between updates.
REQ-016 Full-scale inputs 0x00 and 0xFF SHALL pass unmodified, with no overflow.
REQ-017 The 8-bit output SHALL never wrap.

Reset
REQ-018 During reset, outputs SHALL be: ADC_CS=1, ADC_CLK=0, ADC_DATA_REC=0x00.
REQ-019 During reset, internal state SHALL be: counter 0, state IDLE, discard count cleared.
REQ-020 Reset asserted mid-operation SHALL take effect immediately.
REQ-021 After reset is released, the full IDLE/WAKE/flush sequence SHALL restart.

Configuration
REQ-022 Macro ADC_AVG_EN SHALL control a four-sample averaging filter.
- Defined: ADC_DATA_REC = (sum of the last 4 accepted samples) >> 2, using a 10-bit sum and truncation.
- Defined: the first accepted sample after reset loads all 4 history entries.
- Undefined: ADC_DATA_REC = the raw accepted sample.
- Latency per REQ-015 is identical in both builds.

Structure
REQ-023 Shared package adc_sample_pkg SHALL hold the state enum (IDLE, WAKE, RUN) and the default constants for CLK_DIV, CS_WAKE and PIPE_LAT.
REQ-024 One sub-module, adc_clk_div, SHALL implement the counter, ADC_CLK and a one-cycle rise strobe.
REQ-025 The top level SHALL hold the FSM, capture and filter.

Verification
REQ-026 Reset held, then released -> ADC_CS=1 for exactly 1 cycle, then 0; ADC_CLK first rises 25 SYSCLK cycles after release; period 50, 25 high.
REQ-027 ADC_DAT ramps +1 per ADC_CLK period, no ADC_AVG_EN -> ADC_DATA_REC first changes 1 SYSCLK after the 12th ADC_CLK rise (8 wake, 3 discarded); value = bus value at that rise.
REQ-028 ADC_DAT=0xFF, then 0x00 -> ADC_DATA_REC=0xFF, then 0x00 exactly, no wrap.
REQ-029 ADC_AVG_EN, constant 0x40 then step to 0x80 -> successive outputs 0x40, 0x50, 0x60, 0x70, 0x80.
REQ-030 Reset pulsed while in RUN -> outputs return to 0x00/ADC_CS=1/ADC_CLK=0 asynchronously; after release, 12 rises again before the first update.
REQ-031 ADC_DAT toggling between capture edges -> ADC_DATA_REC reflects only the values at the rise edges.

Source files
------------

// File: rtl/adc_sample_pkg.sv
// adc_sample_pkg: shared FSM state type and default timing constants for the ADC sampler
package adc_sample_pkg;
  typedef enum logic [1:0] {IDLE, WAKE, RUN} state_t;
  localparam int CLK_DIV_DEF = 50;
  localparam int CS_WAKE_DEF = 8;
  localparam int PIPE_LAT_DEF = 3;
endpackage

// File: rtl/adc_clk_div.sv
// adc_clk_div: free-running ADC clock divider with a strobe marking the SYSCLK edge that raises ADC_CLK
module adc_clk_div
  import adc_sample_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic adc_clk,
  output logic rise
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;
  logic [CW-1:0] cnt, cnt_nxt;
  // rise is high in the cycle whose closing edge drives adc_clk 0->1
  always_comb begin
    cnt_nxt = (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
    rise = cnt == CW'(HALF - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      adc_clk <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      adc_clk <= cnt_nxt >= CW'(HALF);
    end
endmodule

// File: rtl/adc_sample_ctl.sv
// adc_sample_ctl: ADC chip-select/wake/flush sequencing and sample capture.
// Define ADC_AVG_EN to replace the raw sample with a 4-sample running average.
module adc_sample_ctl
  import adc_sample_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int CS_WAKE = CS_WAKE_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic       SYSCLK,
  input  logic       RST_B,
  input  logic [7:0] ADC_DAT,
  output logic       ADC_CS,
  output logic       ADC_CLK,
  output logic [7:0] ADC_DATA_REC
);
  localparam int WW = $clog2(CS_WAKE + 2);
  localparam int DW = $clog2(PIPE_LAT + 2);
  state_t state;
  logic [WW-1:0] wake_cnt;
  logic [DW-1:0] disc_cnt;
  logic rise, accept, upd;
  logic [7:0] filt;
  adc_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(SYSCLK),
    .rst(RST_B),
    .adc_clk(ADC_CLK),
    .rise(rise)
  );
  assign ADC_CS = state == IDLE;
  assign accept = state == RUN && rise && disc_cnt == DW'(PIPE_LAT);
  always_ff @(posedge SYSCLK or posedge RST_B)
    if (RST_B) begin
      state <= IDLE;
      wake_cnt <= '0;
      disc_cnt <= '0;
    end else if (state == IDLE) state <= WAKE;
    else if (state == WAKE && rise) begin
      if (wake_cnt == WW'(CS_WAKE - 1)) state <= RUN;
      wake_cnt <= wake_cnt + 1'b1;
    end else if (state == RUN && rise && !accept) disc_cnt <= disc_cnt + 1'b1;
`ifdef ADC_AVG_EN
  logic [3:0][7:0] hist;
  logic primed;
  logic [9:0] sum;
  // the first accepted sample seeds the whole history so the average starts settled
  always_ff @(posedge SYSCLK or posedge RST_B)
    if (RST_B) begin
      hist <= '0;
      primed <= 1'b0;
    end else if (accept) begin
      hist <= primed ? {hist[2:0], ADC_DAT} : {4{ADC_DAT}};
      primed <= 1'b1;
    end
  always_comb begin
    sum = 10'(hist[0]) + 10'(hist[1]) + 10'(hist[2]) + 10'(hist[3]);
    filt = sum[9:2];
  end
`else
  logic [7:0] cap;
  always_ff @(posedge SYSCLK or posedge RST_B)
    if (RST_B) cap <= '0;
    else if (accept) cap <= ADC_DAT;
  assign filt = cap;
`endif
  always_ff @(posedge SYSCLK or posedge RST_B)
    if (RST_B) begin
      upd <= 1'b0;
      ADC_DATA_REC <= '0;
    end else begin
      upd <= accept;
      if (upd) ADC_DATA_REC <= filt;
    end
endmodule

// File: tb/tb_adc_sample_ctl.sv
// tb_adc_sample_ctl: table vectors plus random data against a cycle-count reference model
module tb_adc_sample_ctl;
  localparam int CLK_DIV = 50, CS_WAKE = 8, PIPE_LAT = 3, HALF = CLK_DIV / 2;
  localparam int FIRST = CS_WAKE + PIPE_LAT;
  localparam int NT = 9;
  logic SYSCLK = 0, RST_B = 0, ADC_CS, ADC_CLK;
  logic [7:0] ADC_DAT = 0, ADC_DATA_REC;
  int asserts = 0, fails = 0;
  bit chk_on = 0;
  typedef struct {logic [7:0] dat; logic [7:0] exp;} vec_t;
  vec_t tbl[NT];

  adc_sample_ctl #(.CLK_DIV(CLK_DIV), .CS_WAKE(CS_WAKE), .PIPE_LAT(PIPE_LAT)) dut (
    .SYSCLK(SYSCLK),
    .RST_B(RST_B),
    .ADC_DAT(ADC_DAT),
    .ADC_CS(ADC_CS),
    .ADC_CLK(ADC_CLK),
    .ADC_DATA_REC(ADC_DATA_REC)
  );

  always #10 SYSCLK = ~SYSCLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: e counts SYSCLK edges since reset release; rise n happens at e = HALF + n*CLK_DIV
  int e = 0;
  bit pend = 0;
  logic [7:0] m_rec = 0, pv = 0;
  logic [7:0] acc[$];
  int s;
  always @(posedge SYSCLK or posedge RST_B)
    if (RST_B) begin
      e = 0;
      pend = 0;
      m_rec = 0;
      acc.delete();
    end else begin
      e++;
      if (pend) m_rec = pv;
      pend = 0;
      if (e >= HALF && (e - HALF) % CLK_DIV == 0 && (e - HALF) / CLK_DIV >= FIRST) begin
`ifdef ADC_AVG_EN
        if (acc.size() == 0) repeat (3) acc.push_back(ADC_DAT);
        acc.push_back(ADC_DAT);
        if (acc.size() > 4) void'(acc.pop_front());
        s = 0;
        foreach (acc[i]) s += int'(acc[i]);
        pv = 8'(s / 4);
`else
        pv = ADC_DAT;
`endif
        pend = 1;
      end
    end

  always @(negedge SYSCLK)
    if (chk_on) begin
      chk("adc_cs", 8'(ADC_CS), 8'(e == 0));
      chk("adc_clk", 8'(ADC_CLK), 8'((e % CLK_DIV) >= HALF));
      chk("data_rec", ADC_DATA_REC, m_rec);
    end

  // Runs from a reset-release negedge; c is the number of SYSCLK edges since release
  task automatic run_phase(input int periods, input bit use_tbl);
    int r, a;
    for (int c = 0; c < periods * CLK_DIV; c++) begin
      if (c > 0) @(negedge SYSCLK);
      r = c + 1 - HALF;
      a = r / CLK_DIV - FIRST;
      ADC_DAT = (use_tbl && r >= 0 && r % CLK_DIV == 0 && a >= 0 && a < NT) ? tbl[a].dat : 8'($urandom);
      if (c == HALF + FIRST * CLK_DIV) chk("pre_first", ADC_DATA_REC, 8'h00);
      r = c - HALF - 1;
      a = r / CLK_DIV - FIRST;
      if (use_tbl && r >= 0 && r % CLK_DIV == 0 && a >= 0 && a < NT) chk($sformatf("tbl[%0d]", a), ADC_DATA_REC, tbl[a].exp);
    end
  endtask

  initial begin
    tbl[0] = '{8'h40, 8'h40};
    tbl[1] = '{8'h40, 8'h40};
`ifdef ADC_AVG_EN
    tbl[2] = '{8'h80, 8'h50};
    tbl[3] = '{8'h80, 8'h60};
    tbl[4] = '{8'h80, 8'h70};
    tbl[5] = '{8'h80, 8'h80};
    tbl[6] = '{8'hFF, 8'h9F};
    tbl[7] = '{8'h00, 8'h7F};
    tbl[8] = '{8'h00, 8'h5F};
`else
    tbl[2] = '{8'h80, 8'h80};
    tbl[3] = '{8'h80, 8'h80};
    tbl[4] = '{8'h80, 8'h80};
    tbl[5] = '{8'h80, 8'h80};
    tbl[6] = '{8'hFF, 8'hFF};
    tbl[7] = '{8'h00, 8'h00};
    tbl[8] = '{8'h00, 8'h00};
`endif
    #1 RST_B = 1;
    repeat (3) @(negedge SYSCLK);
    chk_on = 1;
    @(negedge SYSCLK);
    RST_B = 0;
    run_phase(FIRST + NT + 6, 1'b1);
    @(posedge SYSCLK);
    #3 RST_B = 1;
    #1;
    chk("async_cs", 8'(ADC_CS), 8'h01);
    chk("async_clk", 8'(ADC_CLK), 8'h00);
    chk("async_rec", ADC_DATA_REC, 8'h00);
    repeat (4) @(negedge SYSCLK);
    RST_B = 0;
    run_phase(FIRST + 4, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
